wash_run: RTL and testbench

- Cycle-execution stage directly downstream of the admin/settings block.
- Consumes the selected mode, the four per-mode prices, the lid fine and the customer balance, all as 3-digit BCD.
- Debits the price, runs a mm:ss countdown, pauses and charges the fine when the lid opens mid-wash, then raises a completion alarm.
- Drives the remaining-time digits to the display scanner and returns the updated balance to the admin block.

---
 rtl/wash_pkg.sv | 39 +++
 rtl/wash_run_bcd_sub3.sv | 25 ++
 rtl/wash_run.sv | 185 ++++++++++++++++++
 tb/tb_wash_run.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared state codes, widths and mm:ss helper for the wash cycle stage
package wash_pkg;
   localparam int DIGIT_W = 4;
   localparam int MONEY_W = 12;
   localparam int TIME_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_RUN    = 3'd2,
      ST_PAUSE  = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

   localparam logic [1:0] MODE_DRY   = 2'd0;
   localparam logic [1:0] MODE_SMALL = 2'd1;
   localparam logic [1:0] MODE_MED   = 2'd2;
   localparam logic [1:0] MODE_BIG   = 2'd3;

   // One-second decrement of a BCD {m1,m0,s1,s0}; never called on 00:00.
   function automatic logic [TIME_W-1:0] bcd_time_dec(input logic [TIME_W-1:0] t);
      logic [DIGIT_W-1:0] m1, m0, s1, s0;
      {m1, m0, s1, s0} = t;
      if (s0 != 4'd0) s0 = s0 - 4'd1;
      else begin
         s0 = 4'd9;
         if (s1 != 4'd0) s1 = s1 - 4'd1;
         else begin
            s1 = 4'd5;
            if (m0 != 4'd0) m0 = m0 - 4'd1;
            else begin
               m0 = 4'd9;
               m1 = m1 - 4'd1;
            end
         end
      end
      return {m1, m0, s1, s0};
   endfunction
endpackage

// File: rtl/wash_run_bcd_sub3.sv
// rtl/wash_run_bcd_sub3.sv - combinational 3-digit BCD subtractor, borrow_out=1 means a<b
module bcd_sub3
   import wash_pkg::*;
(
   input  logic [MONEY_W-1:0] a,
   input  logic [MONEY_W-1:0] b,
   output logic [MONEY_W-1:0] diff,
   output logic               borrow_out
);
   logic [DIGIT_W:0] t;
   logic             br;

   always_comb begin
      t    = '0;
      br   = 1'b0;
      diff = '0;
      for (int i = 0; i < 3; i++) begin
         t  = {1'b0, a[i*DIGIT_W +: DIGIT_W]} - {1'b0, b[i*DIGIT_W +: DIGIT_W]}
              - {{DIGIT_W{1'b0}}, br};
         br = t[DIGIT_W];
         diff[i*DIGIT_W +: DIGIT_W] = br ? t[DIGIT_W-1:0] + DIGIT_W'(10) : t[DIGIT_W-1:0];
      end
      borrow_out = br;
   end
endmodule

// File: rtl/wash_run.sv
// rtl/wash_run.sv - wash cycle execution: debit, mm:ss countdown, lid pause/fine, alarm
module wash_run
   import wash_pkg::*;
#(
   parameter int          TICK_DIV = 100000000,
   parameter logic [15:0] DUR0     = 16'h0030,
   parameter logic [15:0] DUR1     = 16'h0045,
   parameter logic [15:0] DUR2     = 16'h0100,
   parameter logic [15:0] DUR3     = 16'h0130,
   parameter int          ALARM_S  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [1:0]          mode,
   input  logic [MONEY_W-1:0]  balance,
   input  logic [MONEY_W-1:0]  dy_price,
   input  logic [MONEY_W-1:0]  s_price,
   input  logic [MONEY_W-1:0]  m_price,
   input  logic [MONEY_W-1:0]  b_price,
   input  logic [MONEY_W-1:0]  setfine,
   input  logic                lid_open,
   output logic                busy,
   output logic                motor_on,
   output logic                alarm,
   output logic                done,
   output logic                err_funds,
   output logic                err_lid,
   output logic                fine_short,
   output logic [MONEY_W-1:0]  bal_out,
   output logic                bal_wr,
   output logic [TIME_W-1:0]   rem_bcd,
   output logic [2:0]          state
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW = (ALARM_S > 1) ? $clog2(ALARM_S) : 1;

   state_e             state_q, state_d;
   logic [PW-1:0]      presc_q, presc_d;
   logic [AW-1:0]      acnt_q, acnt_d;
   logic [1:0]         mode_q, mode_d;
   logic [MONEY_W-1:0] price_q, price_d, bal_q, bal_d;
   logic [TIME_W-1:0]  rem_q, rem_d;
   logic busy_q, busy_d, motor_q, motor_d, alarm_q, alarm_d, done_q, done_d;
   logic efunds_q, efunds_d, elid_q, elid_d, fshort_q, fshort_d, balwr_q, balwr_d;

   logic               tick;
   logic [MONEY_W-1:0] sub_a, sub_b, sub_diff;
   logic               sub_borrow;
   logic [MONEY_W-1:0] price_sel;
   logic [TIME_W-1:0]  dur_sel;

   // The single subtractor serves the price debit in CHECK and the fine in RUN.
   assign sub_a = (state_q == ST_CHECK) ? balance : bal_q;
   assign sub_b = (state_q == ST_CHECK) ? price_q : setfine;

   bcd_sub3 u_sub (.a(sub_a), .b(sub_b), .diff(sub_diff), .borrow_out(sub_borrow));

   assign tick = (presc_q == PW'(TICK_DIV - 1));

   always_comb begin
      case (mode)
         MODE_DRY:   price_sel = dy_price;
         MODE_SMALL: price_sel = s_price;
         MODE_MED:   price_sel = m_price;
         default:    price_sel = b_price;
      endcase
      case (mode_q)
         MODE_DRY:   dur_sel = DUR0;
         MODE_SMALL: dur_sel = DUR1;
         MODE_MED:   dur_sel = DUR2;
         default:    dur_sel = DUR3;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      acnt_d   = acnt_q;
      mode_d   = mode_q;
      price_d  = price_q;
      bal_d    = bal_q;
      rem_d    = rem_q;
      done_d   = 1'b0;
      efunds_d = 1'b0;
      elid_d   = 1'b0;
      fshort_d = 1'b0;
      balwr_d  = 1'b0;
      if (state_q == ST_RUN || state_q == ST_FINISH)
         presc_d = tick ? '0 : presc_q + PW'(1);
      case (state_q)
         ST_IDLE: if (start) begin
            if (lid_open) elid_d = 1'b1;
            else begin
               mode_d  = mode;
               price_d = price_sel;
               presc_d = '0;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: if (!sub_borrow) begin
            bal_d   = sub_diff;
            balwr_d = 1'b1;
            rem_d   = dur_sel;
            state_d = ST_RUN;
         end else begin
            efunds_d = 1'b1;
            state_d  = ST_IDLE;
         end
         ST_RUN: if (abort) state_d = ST_IDLE;
         else if (lid_open) begin
            state_d  = ST_PAUSE;
            balwr_d  = 1'b1;
            bal_d    = sub_borrow ? '0 : sub_diff;
            fshort_d = sub_borrow;
         end else if (tick) begin
            if (rem_q == 16'h0001) begin
               rem_d   = '0;
               done_d  = 1'b1;
               acnt_d  = '0;
               state_d = ST_FINISH;
            end else rem_d = bcd_time_dec(rem_q);
         end
         ST_PAUSE: if (abort) state_d = ST_IDLE;
         else if (!lid_open) state_d = ST_RUN;
         ST_FINISH: if (tick) begin
            if (acnt_q == AW'(ALARM_S - 1)) state_d = ST_IDLE;
            else acnt_d = acnt_q + AW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d  = (state_d != ST_IDLE);
      motor_d = (state_d == ST_RUN);
      alarm_d = (state_d == ST_FINISH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         acnt_q  <= '0;
         mode_q  <= '0;
         price_q <= '0;
         bal_q   <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         motor_q <= 1'b0;
         alarm_q <= 1'b0;
         done_q  <= 1'b0;
         efunds_q <= 1'b0;
         elid_q  <= 1'b0;
         fshort_q <= 1'b0;
         balwr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         acnt_q  <= acnt_d;
         mode_q  <= mode_d;
         price_q <= price_d;
         bal_q   <= bal_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         motor_q <= motor_d;
         alarm_q <= alarm_d;
         done_q  <= done_d;
         efunds_q <= efunds_d;
         elid_q  <= elid_d;
         fshort_q <= fshort_d;
         balwr_q <= balwr_d;
      end
   end

   assign state      = state_q;
   assign busy       = busy_q;
   assign motor_on   = motor_q;
   assign alarm      = alarm_q;
   assign done       = done_q;
   assign err_funds  = efunds_q;
   assign err_lid    = elid_q;
   assign fine_short = fshort_q;
   assign bal_out    = bal_q;
   assign bal_wr     = balwr_q;
   assign rem_bcd    = rem_q;
endmodule

// File: tb/tb_wash_run.sv
// tb/tb_wash_run.sv - directed self-checking bench for wash_run with TICK_DIV=4
module tb_wash_run;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, lid_open = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [11:0] balance = '0, dy_price = '0, s_price = '0, m_price = '0, b_price = '0, setfine = '0;
   logic        busy, motor_on, alarm, done, err_funds, err_lid, fine_short, bal_wr;
   logic [11:0] bal_out;
   logic [15:0] rem_bcd;
   logic [2:0]  state;
   int checks = 0, fails = 0;

   wash_run #(.TICK_DIV(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .balance(balance),
      .dy_price(dy_price), .s_price(s_price), .m_price(m_price), .b_price(b_price),
      .setfine(setfine), .lid_open(lid_open), .busy(busy), .motor_on(motor_on),
      .alarm(alarm), .done(done), .err_funds(err_funds), .err_lid(err_lid),
      .fine_short(fine_short), .bal_out(bal_out), .bal_wr(bal_wr), .rem_bcd(rem_bcd),
      .state(state));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      checks++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
      checks++; if ({busy, motor_on, alarm, done, bal_wr, bal_out, rem_bcd} !== '0) begin fails++;
         $display("FAIL reset_outputs: got bal=%h rem=%h busy=%b expected all zero", bal_out, rem_bcd, busy); end
   endtask

   task automatic test_normal_run();
      int n = 0, k = 0;
      balance = 12'h050; mode = 2'd1; s_price = 12'h020; start = 1'b1;
      step(); start = 1'b0;
      checks++; if (state !== 3'd1 || busy !== 1'b1) begin fails++; $display("FAIL check_state: got %0d expected 1", state); end
      step();
      checks++; if (state !== 3'd2 || motor_on !== 1'b1) begin fails++; $display("FAIL run_entry: got %0d expected 2", state); end
      checks++; if (bal_out !== 12'h030 || bal_wr !== 1'b1) begin fails++; $display("FAIL debit: got %h wr=%b expected 030 wr=1", bal_out, bal_wr); end
      checks++; if (rem_bcd !== 16'h0045) begin fails++; $display("FAIL dur1: got %h expected 0045", rem_bcd); end
      for (int i = 1; i <= 400 && n == 0; i++) begin
         step();
         if (i == 3) begin checks++; if (rem_bcd !== 16'h0045) begin fails++; $display("FAIL pre_tick: got %h expected 0045", rem_bcd); end end
         if (i == 4) begin checks++; if (rem_bcd !== 16'h0044) begin fails++; $display("FAIL first_tick: got %h expected 0044", rem_bcd); end end
         if (done) n = i;
      end
      checks++; if (n != 180) begin fails++; $display("FAIL done_latency: got %0d cycles expected 180", n); end
      checks++; if (alarm !== 1'b1 || state !== 3'd4 || rem_bcd !== 16'h0000 || motor_on !== 1'b0) begin fails++;
         $display("FAIL finish: got alarm=%b state=%0d rem=%h expected 1 4 0000", alarm, state, rem_bcd); end
      for (int j = 1; j <= 100 && state != 3'd0; j++) begin
         step(); k = j;
         if (j == 1) begin checks++; if (done !== 1'b0) begin fails++; $display("FAIL done_pulse: got %b expected 0", done); end end
      end
      checks++; if (k != 12 || alarm !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL alarm_len: got %0d cycles expected 12", k); end
   endtask

   task automatic test_insufficient();
      balance = 12'h015; mode = 2'd1; s_price = 12'h020; start = 1'b1;
      step(); start = 1'b0;
      step();
      checks++; if (err_funds !== 1'b1 || state !== 3'd0) begin fails++; $display("FAIL err_funds: got %b state=%0d expected 1 0", err_funds, state); end
      checks++; if (bal_out !== 12'h030 || bal_wr !== 1'b0) begin fails++; $display("FAIL funds_bal: got %h wr=%b expected 030 wr=0", bal_out, bal_wr); end
      step();
      checks++; if (err_funds !== 1'b0) begin fails++; $display("FAIL err_funds_pulse: got %b expected 0", err_funds); end
   endtask

   task automatic test_lid_fine();
      int wr_cnt = 0;
      balance = 12'h050; mode = 2'd1; s_price = 12'h020; setfine = 12'h010; start = 1'b1;
      step(); start = 1'b0;
      step();
      repeat (5) step();
      checks++; if (rem_bcd !== 16'h0044) begin fails++; $display("FAIL pre_lid_rem: got %h expected 0044", rem_bcd); end
      lid_open = 1'b1;
      step();
      checks++; if (state !== 3'd3 || motor_on !== 1'b0) begin fails++; $display("FAIL pause: got %0d expected 3", state); end
      checks++; if (bal_out !== 12'h020 || bal_wr !== 1'b1 || fine_short !== 1'b0) begin fails++;
         $display("FAIL fine: got %h wr=%b short=%b expected 020 1 0", bal_out, bal_wr, fine_short); end
      repeat (40) begin step(); if (bal_wr) wr_cnt++; end
      checks++; if (wr_cnt != 0 || bal_out !== 12'h020 || rem_bcd !== 16'h0044 || state !== 3'd3) begin fails++;
         $display("FAIL pause_hold: got wr=%0d bal=%h rem=%h expected 0 020 0044", wr_cnt, bal_out, rem_bcd); end
      lid_open = 1'b0;
      step();
      checks++; if (state !== 3'd2 || rem_bcd !== 16'h0044) begin fails++; $display("FAIL resume: got %0d rem=%h expected 2 0044", state, rem_bcd); end
      step(); step();
      checks++; if (rem_bcd !== 16'h0043) begin fails++; $display("FAIL presc_hold: got %h expected 0043", rem_bcd); end
      abort = 1'b1; step(); abort = 1'b0;
      checks++; if (state !== 3'd0 || bal_out !== 12'h020) begin fails++; $display("FAIL abort_refund: got %0d bal=%h expected 0 020", state, bal_out); end
   endtask

   task automatic test_fine_short();
      balance = 12'h025; mode = 2'd1; s_price = 12'h020; setfine = 12'h010; start = 1'b1;
      step(); start = 1'b0;
      step();
      checks++; if (bal_out !== 12'h005) begin fails++; $display("FAIL short_debit: got %h expected 005", bal_out); end
      lid_open = 1'b1;
      step();
      checks++; if (bal_out !== 12'h000 || fine_short !== 1'b1 || bal_wr !== 1'b1) begin fails++;
         $display("FAIL fine_short: got %h short=%b expected 000 1", bal_out, fine_short); end
      step();
      checks++; if (fine_short !== 1'b0) begin fails++; $display("FAIL short_pulse: got %b expected 0", fine_short); end
      abort = 1'b1; step(); abort = 1'b0; lid_open = 1'b0;
      checks++; if (state !== 3'd0) begin fails++; $display("FAIL pause_abort: got %0d expected 0", state); end
   endtask

   task automatic test_minute_borrow();
      balance = 12'h100; mode = 2'd3; b_price = 12'h010; start = 1'b1;
      step(); start = 1'b0;
      step();
      checks++; if (rem_bcd !== 16'h0130 || bal_out !== 12'h090) begin fails++; $display("FAIL dur3: got %h bal=%h expected 0130 090", rem_bcd, bal_out); end
      repeat (120) step();
      checks++; if (rem_bcd !== 16'h0100) begin fails++; $display("FAIL rem_30: got %h expected 0100", rem_bcd); end
      repeat (4) step();
      checks++; if (rem_bcd !== 16'h0059) begin fails++; $display("FAIL minute_borrow: got %h expected 0059", rem_bcd); end
      abort = 1'b1; step(); abort = 1'b0;
      checks++; if (state !== 3'd0 || motor_on !== 1'b0 || busy !== 1'b0 || bal_out !== 12'h090) begin fails++;
         $display("FAIL abort: got %0d motor=%b bal=%h expected 0 0 090", state, motor_on, bal_out); end
   endtask

   task automatic test_lid_start();
      lid_open = 1'b1; mode = 2'd0; start = 1'b1;
      step(); start = 1'b0;
      checks++; if (err_lid !== 1'b1 || state !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL err_lid: got %b state=%0d expected 1 0", err_lid, state); end
      step(); lid_open = 1'b0;
      checks++; if (err_lid !== 1'b0) begin fails++; $display("FAIL err_lid_pulse: got %b expected 0", err_lid); end
   endtask

   task automatic test_tick_lid();
      balance = 12'h040; mode = 2'd0; dy_price = 12'h000; setfine = 12'h010; start = 1'b1;
      step(); start = 1'b0;
      step();
      checks++; if (bal_out !== 12'h040 || bal_wr !== 1'b1 || rem_bcd !== 16'h0030) begin fails++;
         $display("FAIL zero_price: got %h wr=%b rem=%h expected 040 1 0030", bal_out, bal_wr, rem_bcd); end
      repeat (3) step();
      lid_open = 1'b1;
      step();
      checks++; if (state !== 3'd3 || rem_bcd !== 16'h0030 || bal_out !== 12'h030) begin fails++;
         $display("FAIL tick_lid: got %0d rem=%h bal=%h expected 3 0030 030", state, rem_bcd, bal_out); end
      lid_open = 1'b0; step();
   endtask

   task automatic test_reset_mid_run();
      checks++; if (state !== 3'd2) begin fails++; $display("FAIL pre_reset_run: got %0d expected 2", state); end
      rst = 1'b1; step(); rst = 1'b0;
      checks++; if (state !== 3'd0 || {busy, motor_on, alarm, bal_wr, bal_out, rem_bcd} !== '0) begin fails++;
         $display("FAIL reset_mid_run: got state=%0d bal=%h rem=%h expected all zero", state, bal_out, rem_bcd); end
   endtask

   initial begin
      test_reset();
      test_normal_run();
      test_insufficient();
      test_lid_fine();
      test_fine_short();
      test_minute_borrow();
      test_lid_start();
      test_tick_lid();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
